// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: aligns store lanes, extends load data and runs one
// request/grant/response bus transaction at a time while stalling the pipeline.
module mem_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_res,
    input  logic [31:0] bypass_op2,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        lsu_exc,
    output logic [1:0]  lsu_exc_cause,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [29:0] waddr_q, waddr_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        exc_q, exc_d;
    logic [1:0]  cause_q, cause_d;

    logic start, illegal, misaligned, timeout;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   store_be = 4'b0001 << off;
            2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   store_lanes = {4{d[7:0]}};
            2'b01:   store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_ext = {24'd0, sh[7:0]};
            3'b101:  load_ext = {16'd0, sh[15:0]};
            default: load_ext = rdata;
        endcase
    endfunction

    assign start      = ex_valid & (mem_read | mem_write);
    // Unsigned widths exist only for loads; illegal outranks misaligned.
    assign illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (mem_write && funct3[2]);
    assign misaligned = ((funct3[1:0] == 2'b01) && alu_res[0]) ||
                        ((funct3[1:0] == 2'b10) && (alu_res[1:0] != 2'b00));
    assign timeout    = (cnt_q >= TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (illegal || misaligned) ? DONE : REQ;
            REQ:  if (timeout) state_d = DONE;
                  else if (dmem_gnt) state_d = RESP;
            RESP: if (dmem_rvalid || timeout) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dmem_req      = (state_q == REQ);
        mem_stall     = rst_n && (((state_q == IDLE) && start) || (state_q == REQ) || (state_q == RESP));
        wb_valid      = (state_q == DONE) && !exc_q;
        lsu_exc       = (state_q == DONE) && exc_q;
        lsu_exc_cause = cause_q;
        wb_data       = wb_data_q;
        dmem_we       = we_q;
        dmem_addr     = {waddr_q, 2'b00};
        dmem_be       = be_q;
        dmem_wdata    = wdata_q;
    end

    always_comb begin
        cnt_d     = cnt_q;
        waddr_d   = waddr_q;
        off_d     = off_q;
        f3_d      = f3_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        wb_data_d = wb_data_q;
        exc_d     = exc_q;
        cause_d   = cause_q;
        case (state_q)
            IDLE: if (start) begin
                exc_d = illegal || misaligned;
                cnt_d = 8'd0;
                if (illegal) begin
                    cause_d   = 2'b11;
                    wb_data_d = 32'd0;
                end else if (misaligned) begin
                    cause_d   = 2'b01;
                    wb_data_d = 32'd0;
                end else begin
                    waddr_d = alu_res[31:2];
                    off_d   = alu_res[1:0];
                    f3_d    = funct3;
                    we_d    = mem_write;
                    be_d    = mem_write ? store_be(funct3, alu_res[1:0]) : 4'b1111;
                    wdata_d = mem_write ? store_lanes(funct3, bypass_op2) : 32'd0;
                end
            end
            REQ, RESP: begin
                cnt_d = cnt_q + 8'd1;
                // A response in RESP wins over a timeout expiring in the same cycle.
                if ((state_q == RESP) && dmem_rvalid) begin
                    exc_d     = 1'b0;
                    wb_data_d = we_q ? 32'd0 : load_ext(f3_q, off_q, dmem_rdata);
                end else if (timeout) begin
                    exc_d     = 1'b1;
                    cause_d   = 2'b10;
                    wb_data_d = 32'd0;
                end
            end
            default: ;
        endcase
    end

    // Data registers are reset too, so every bus/writeback output reads 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 8'd0;
            waddr_q   <= 30'd0;
            off_q     <= 2'd0;
            f3_q      <= 3'd0;
            we_q      <= 1'b0;
            be_q      <= 4'd0;
            wdata_q   <= 32'd0;
            wb_data_q <= 32'd0;
            exc_q     <= 1'b0;
            cause_q   <= 2'd0;
        end else begin
            cnt_q     <= cnt_d;
            waddr_q   <= waddr_d;
            off_q     <= off_d;
            f3_q      <= f3_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            wb_data_q <= wb_data_d;
            exc_q     <= exc_d;
            cause_q   <= cause_d;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: table of single accesses plus hand-written
// timeout, stray-response and reset sequences, with a simple bus responder.
module tb_mem_lsu;
    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_res, bypass_op2;
    logic        mem_stall, wb_valid, lsu_exc;
    logic [31:0] wb_data;
    logic [1:0]  lsu_exc_cause;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    int checks = 0;
    int fails  = 0;

    mem_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .alu_res(alu_res), .bypass_op2(bypass_op2),
        .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_data(wb_data), .lsu_exc(lsu_exc),
        .lsu_exc_cause(lsu_exc_cause), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] op2;
        logic [31:0] rdata;
        int          gnt_dly;
        logic        exc;
        logic [1:0]  cause;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] wb;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; alu_res = 32'd0; bypass_op2 = 32'd0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   cyc, req_n;
        logic done;
        string p;
        v = vecs[i];
        p = $sformatf("v%0d", i);
        @(negedge clk);
        ex_valid = 1'b1; mem_read = v.rd; mem_write = v.wr;
        funct3 = v.f3; alu_res = v.addr; bypass_op2 = v.op2;
        #1 chk({p, "_stall_T"}, 32'(mem_stall), 32'd1);
        @(negedge clk);
        drive_idle();
        if (v.exc) begin
            chk({p, "_exc"}, 32'(lsu_exc), 32'd1);
            chk({p, "_cause"}, 32'(lsu_exc_cause), 32'(v.cause));
            chk({p, "_noreq"}, 32'(dmem_req), 32'd0);
            chk({p, "_stall_T1"}, 32'(mem_stall), 32'd0);
            chk({p, "_nowb"}, 32'(wb_valid), 32'd0);
            @(negedge clk);
            chk({p, "_exc_pulse"}, 32'(lsu_exc), 32'd0);
        end else begin
            cyc = 1; req_n = 0; done = 1'b0;
            while (!done && cyc < 40) begin
                if (wb_valid || lsu_exc) begin
                    done = 1'b1;
                end else if (dmem_req) begin
                    req_n++;
                    if (req_n == 1) begin
                        chk({p, "_addr"}, dmem_addr, v.addr & 32'hFFFF_FFFC);
                        chk({p, "_we"}, 32'(dmem_we), 32'(v.wr));
                        chk({p, "_be"}, 32'(dmem_be), 32'(v.be));
                        if (v.wr) chk({p, "_wdata"}, dmem_wdata, v.wdata);
                    end
                    dmem_gnt = (req_n > v.gnt_dly);
                    @(negedge clk); cyc++;
                end else if (mem_stall) begin
                    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
                    @(negedge clk); cyc++;
                end else begin
                    @(negedge clk); cyc++;
                end
            end
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            chk({p, "_completed"}, 32'(done), 32'd1);
            chk({p, "_latency"}, 32'(cyc), 32'(3 + v.gnt_dly));
            chk({p, "_req_cycles"}, 32'(req_n), 32'(v.gnt_dly + 1));
            chk({p, "_wb_data"}, wb_data, v.wb);
            chk({p, "_noexc"}, 32'(lsu_exc), 32'd0);
            chk({p, "_stall_done"}, 32'(mem_stall), 32'd0);
            @(negedge clk);
            chk({p, "_wb_pulse"}, 32'(wb_valid), 32'd0);
            chk({p, "_wb_hold"}, wb_data, v.wb);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   req_n, cyc;
        logic hit;

        //            rd wr f3      addr          op2           rdata        dly exc cause be     wdata         wb
        vecs[0]  = '{1, 0, 3'b000, 32'h0000_1003, 32'h0,        32'h8012_3456, 0, 0, 2'b00, 4'hF, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{1, 0, 3'b100, 32'h0000_1003, 32'h0,        32'h8012_3456, 0, 0, 2'b00, 4'hF, 32'h0,        32'h0000_0080};
        vecs[2]  = '{0, 1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,        3, 0, 2'b00, 4'hC, 32'hBEEF_BEEF, 32'h0};
        vecs[3]  = '{1, 0, 3'b010, 32'h0000_3001, 32'h0,        32'h0,         0, 1, 2'b01, 4'h0, 32'h0,        32'h0};
        vecs[4]  = '{0, 1, 3'b100, 32'h0000_3000, 32'h0,        32'h0,         0, 1, 2'b11, 4'h0, 32'h0,        32'h0};
        vecs[5]  = '{1, 0, 3'b111, 32'h0000_3000, 32'h0,        32'h0,         0, 1, 2'b11, 4'h0, 32'h0,        32'h0};
        vecs[6]  = '{1, 0, 3'b001, 32'h0000_1002, 32'h0,        32'h8012_3456, 1, 0, 2'b00, 4'hF, 32'h0,        32'hFFFF_8012};
        vecs[7]  = '{1, 0, 3'b101, 32'h0000_1000, 32'h0,        32'h1234_F00D, 0, 0, 2'b00, 4'hF, 32'h0,        32'h0000_F00D};
        vecs[8]  = '{1, 0, 3'b010, 32'h0000_1004, 32'h0,        32'hCAFE_BABE, 4, 0, 2'b00, 4'hF, 32'h0,        32'hCAFE_BABE};
        vecs[9]  = '{0, 1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 32'h0,        0, 0, 2'b00, 4'h2, 32'hA5A5_A5A5, 32'h0};
        vecs[10] = '{0, 1, 3'b010, 32'h0000_0000, 32'h1234_5678, 32'h0,        1, 0, 2'b00, 4'hF, 32'h1234_5678, 32'h0};
        vecs[11] = '{0, 1, 3'b001, 32'h0000_5003, 32'h0,        32'h0,         0, 1, 2'b01, 4'h0, 32'h0,        32'h0};
        vecs[12] = '{1, 0, 3'b000, 32'h0000_7001, 32'h0,        32'h0000_7F00, 0, 0, 2'b00, 4'hF, 32'h0,        32'h0000_007F};
        vecs[13] = '{0, 1, 3'b001, 32'h0000_4000, 32'h0000_CAFE, 32'h0,        2, 0, 2'b00, 4'h3, 32'hCAFE_CAFE, 32'h0};
        vecs[14] = '{0, 1, 3'b101, 32'h0000_5001, 32'h0,        32'h0,         0, 1, 2'b11, 4'h0, 32'h0,        32'h0};

        rst_n = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        drive_idle();
        ex_valid = 1'b1; mem_read = 1'b1;
        #23;
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_exc", 32'(lsu_exc), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(i);

        // Read that is never granted: exception after TO request cycles.
        @(negedge clk);
        ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_res = 32'h40;
        @(negedge clk);
        drive_idle();
        req_n = 0; cyc = 1; hit = 1'b0;
        while (!hit && cyc < 30) begin
            if (lsu_exc || wb_valid) hit = 1'b1;
            else begin
                if (dmem_req) req_n++;
                @(negedge clk); cyc++;
            end
        end
        chk("to_exc", 32'(lsu_exc), 32'd1);
        chk("to_cause", 32'(lsu_exc_cause), 32'd2);
        chk("to_req_cycles", 32'(req_n), 32'(TO));
        chk("to_req_dropped", 32'(dmem_req), 32'd0);
        chk("to_stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("late_rvalid_wb", 32'(wb_valid), 32'd0);
        chk("late_rvalid_exc", 32'(lsu_exc), 32'd0);
        chk("late_rvalid_stall", 32'(mem_stall), 32'd0);
        run_vec(8);

        // Reset in the middle of a request.
        @(negedge clk);
        ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_res = 32'h6000;
        @(negedge clk);
        drive_idle();
        chk("mid_req", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(dmem_req), 32'd0);
        chk("arst_stall", 32'(mem_stall), 32'd0);
        chk("arst_wb_valid", 32'(wb_valid), 32'd0);
        chk("arst_wb_data", wb_data, 32'd0);
        chk("arst_addr", dmem_addr, 32'd0);
        chk("arst_be", 32'(dmem_be), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("stray_rvalid_wb", 32'(wb_valid), 32'd0);
        chk("stray_rvalid_stall", 32'(mem_stall), 32'd0);
        run_vec(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the MEM stage of the RISC-V pipeline. Consumes the EX-stage outputs `alu_res` (effective address) and `bypass_op2` (forwarded store data) and runs a request/grant/response transaction on the data-memory bus. It handles:

- byte-lane alignment for stores;
- extraction and sign/zero extension for loads;
- pipeline stall while a transaction is outstanding;
- misaligned, illegal-width and bus-timeout exceptions.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum cycles spent waiting in REQ plus RESP before a bus error is declared; range 2..255.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ex_valid`  in  1  EX/MEM register holds a valid instruction.
- `mem_read`  in  1  instruction is a load.
- `mem_write`  in  1  instruction is a store; never both high with `mem_read`.
- `funct3`  in  3  access width: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `alu_res`  in  32  effective address.
- `bypass_op2`  in  32  store data, already forwarded.
- `mem_stall`  out  1  freeze IF..EX/MEM registers.
- `wb_valid`  out  1  one-cycle pulse: access completed.
- `wb_data`  out  32  load result, extended; 0 for stores.
- `lsu_exc`  out  1  one-cycle exception pulse.
- `lsu_exc_cause`  out  2  01 misaligned, 10 bus timeout, 11 illegal width.
- `dmem_req`  out  1  bus request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  32  word address, `{alu_res[31:2],2'b00}`.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  response valid (read data or write ack).
- `dmem_rdata`  in  32  read data.

## Operation

FSM states: IDLE, REQ, RESP, DONE.

**Start condition**
- `start = ex_valid & (mem_read | mem_write)`, evaluated only in IDLE.

**Checks on start, in priority order**
1. Illegal width (funct3 011/110/111, or 100/101 with a store) → cause 11.
2. Misaligned (H/HU with `addr[0]`=1, W with `addr[1:0]`≠0) → cause 01.
3. Otherwise latch address, offset, funct3, we, be and wdata; go to REQ.

Both faults: no bus activity; go to DONE with the exception flagged.

**State behaviour**
- REQ: `dmem_req`=1 with stable addr/we/be/wdata. On `dmem_gnt`, go to RESP.
- RESP: wait for `dmem_rvalid`. On it, capture the extended load data and go to DONE.
- DONE: pulse `wb_valid` (no exception) or `lsu_exc` (with cause). Always go to IDLE. `ex_valid` is ignored in DONE.
- Timeout: a counter clears on entry to REQ and increments in REQ and RESP. When it reaches `TIMEOUT_CYCLES` without completion, go to DONE with cause 10 and drop `dmem_req`. A late `rvalid` arriving in IDLE is ignored.

**Store lanes**
- SB: `be = 4'b0001 << off`, `wdata = {4{d[7:0]}}`.
- SH: `be = off[1] ? 1100 : 0011`, `wdata = {2{d[15:0]}}`.
- SW: `be = 1111`, `wdata = d`.

**Load data**
- `sh = dmem_rdata >> (8*off)`.
- LB/LH sign-extend `sh[7:0]` / `sh[15:0]`.
- LBU/LHU zero-extend.
- LW passes `dmem_rdata` unchanged.

**Output timing**
- `wb_data` is registered and held until the next DONE.
- `lsu_exc_cause` holds its last value and is meaningful only while `lsu_exc`=1.

## Timing

- `mem_stall = (IDLE & start) | REQ | RESP`. It is low in DONE, so the pipeline advances at the end of the DONE cycle.
- Minimum load/store latency: accepted at T, `dmem_req` at T+1; `gnt` at T+1 → RESP at T+2; `rvalid` at T+2 → `wb_valid` at T+3. Stall is high for T..T+2.
- `gnt` and `rvalid` in the same cycle in REQ: the response is not accepted. A responder must deliver `rvalid` no earlier than the cycle after `gnt`.
- Fault path: detected at T, `lsu_exc` at T+1, stall high at T only.
- Reset while `rst_n`=0, any state: FSM goes to IDLE and counter to 0. All outputs are 0: `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata`, `mem_stall`, `wb_valid`, `wb_data`, `lsu_exc`, `lsu_exc_cause`. `dmem_req` drops asynchronously. The first start is accepted in the cycle after `rst_n` rises.

## Test plan

- LB at `alu_res`=0x1003, memory word 0x80_12_34_56; `gnt` at T+1, `rvalid` at T+2 → `dmem_addr`=0x1000, `be`=1111 ignored for read, `wb_valid` at T+3, `wb_data`=0xFFFFFF80. Repeat as LBU → 0x00000080.
- SH at 0x2002 with `bypass_op2`=0xDEADBEEF, `gnt` delayed 3 cycles → `dmem_req` held 4 cycles with `be`=1100, `wdata`=0xBEEFBEEF; `mem_stall` high until `rvalid`; `wb_data`=0.
- LW at 0x3001 → no `dmem_req`; `lsu_exc`=1 with cause 01 one cycle later; stall high exactly one cycle.
- Store with funct3=100 → cause 11. Load with funct3=111 → cause 11.
- Read with no `gnt` and `TIMEOUT_CYCLES`=4 → `lsu_exc` cause 10 after 4 REQ cycles; `dmem_req` drops; a following LW completes normally.
- Assert `rst_n`=0 during RESP → `dmem_req`, `mem_stall` and `wb_valid` go to 0 immediately. After release, a stray `rvalid` is ignored and a new SW at 0x0 issues `be`=1111.
